// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM with ALU function decoder.
// Walks each instruction through fetch, decode, execute, memory and
// writeback states, and drives every datapath select and enable.
// Memory states may be stretched by wait states through mem_ready.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   op, funct  opcode and function fields from the instruction register
//   zero       ALU zero flag (for beq)
//   mem_ready  memory access completes this cycle
//   iord, memread, memwrite, irwrite          memory and IR control
//   regdst, memtoreg, regwrite                register file control
//   alusrca, alusrcb, alucontrol              ALU operand and function
//   pcsrc, pcen                               next-PC select and load
//   illegal    one-cycle pulse on an unsupported opcode or funct
//   state      current FSM state, for debug
module mc_controller #(
  parameter bit USE_MEMREADY = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       illegal,
  output logic [3:0] state
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_e;

  state_e state_q, state_d;

  // Effective memory handshake; tied high when wait states are disabled.
  logic mem_rdy;
  assign mem_rdy = USE_MEMREADY ? mem_ready : 1'b1;

  // ALU function decoder for R-type instructions.
  logic             funct_ok;
  logic [ALU_W-1:0] funct_alu;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      FN_ADD:  funct_alu = ALU_ADD;
      FN_SUB:  funct_alu = ALU_SUB;
      FN_AND:  funct_alu = ALU_AND;
      FN_OR:   funct_alu = ALU_OR;
      FN_SLT:  funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-state control word, before reset gating.
  logic             ctl_iord;
  logic             ctl_memread;
  logic             ctl_memwrite;
  logic             ctl_irwrite;
  logic             ctl_regdst;
  logic             ctl_memtoreg;
  logic             ctl_regwrite;
  logic             ctl_alusrca;
  logic [1:0]       ctl_alusrcb;
  logic [1:0]       ctl_pcsrc;
  logic [ALU_W-1:0] ctl_alu;
  logic             ctl_pcwrite;
  logic             ctl_branch;
  logic             ctl_illegal;

  // Next-state and Moore control decode.
  always_comb begin
    state_d      = state_q;
    ctl_iord     = 1'b0;
    ctl_memread  = 1'b0;
    ctl_memwrite = 1'b0;
    ctl_irwrite  = 1'b0;
    ctl_regdst   = 1'b0;
    ctl_memtoreg = 1'b0;
    ctl_regwrite = 1'b0;
    ctl_alusrca  = 1'b0;
    ctl_alusrcb  = 2'b00;
    ctl_pcsrc    = 2'b00;
    ctl_alu      = ALU_ADD;
    ctl_pcwrite  = 1'b0;
    ctl_branch   = 1'b0;
    ctl_illegal  = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 through the ALU; IR and PC load only when the read lands.
        ctl_memread = 1'b1;
        ctl_alusrcb = 2'b01;
        if (mem_rdy) begin
          ctl_irwrite = 1'b1;
          ctl_pcwrite = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut while decoding.
        ctl_alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_EXECUTE;
            end else begin
              ctl_illegal = 1'b1;
              state_d     = S_FETCH;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_ADDI: state_d = S_ADDIEX;
          OP_J:    state_d = S_JUMP;
          default: begin
            ctl_illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctl_alusrca = 1'b1;
        ctl_alusrcb = 2'b10;
        state_d     = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ctl_memread = 1'b1;
        ctl_iord    = 1'b1;
        if (mem_rdy) begin
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctl_memtoreg = 1'b1;
        ctl_regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        // Single write strobe, issued in the completing cycle only.
        ctl_iord = 1'b1;
        if (mem_rdy) begin
          ctl_memwrite = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_EXECUTE: begin
        ctl_alusrca = 1'b1;
        ctl_alu     = funct_alu;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        ctl_regdst   = 1'b1;
        ctl_regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        ctl_alusrca = 1'b1;
        ctl_alu     = ALU_SUB;
        ctl_pcsrc   = 2'b01;
        ctl_branch  = 1'b1;
        state_d     = S_FETCH;
      end
      S_ADDIEX: begin
        ctl_alusrca = 1'b1;
        ctl_alusrcb = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        ctl_regwrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        ctl_pcsrc   = 2'b10;
        ctl_pcwrite = 1'b1;
        state_d     = S_FETCH;
      end
      default: begin
        // Unused encodings recover to fetch with every control quiet.
        ctl_alu = 3'b000;
        state_d = S_FETCH;
      end
    endcase
  end

  // Outputs are held at zero for as long as reset is asserted.
  always_comb begin
    iord       = reset & ctl_iord;
    memread    = reset & ctl_memread;
    memwrite   = reset & ctl_memwrite;
    irwrite    = reset & ctl_irwrite;
    regdst     = reset & ctl_regdst;
    memtoreg   = reset & ctl_memtoreg;
    regwrite   = reset & ctl_regwrite;
    alusrca    = reset & ctl_alusrca;
    alusrcb    = reset ? ctl_alusrcb : 2'b00;
    pcsrc      = reset ? ctl_pcsrc : 2'b00;
    alucontrol = reset ? ctl_alu : 3'b000;
    pcen       = reset & (ctl_pcwrite | (ctl_branch & zero));
    illegal    = reset & ctl_illegal;
    state      = 4'(state_q);
  end

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed vector table, hand
// sequences for reset behaviour, and randomized instructions against an
// instruction-level reference model.
module tb_mc_controller;

  typedef struct packed {
    logic [3:0] st;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic       pcen;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
    out_t       exp;
  } cyc_t;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  localparam int K_LW = 0, K_SW = 1, K_R = 2, K_BEQ = 3, K_ADDI = 4, K_J = 5, K_ILL = 6;

  // Expected output words, field order as in out_t:
  // st, {iord,memread,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca},
  // alusrcb, pcsrc, alucontrol, pcen, illegal
  localparam out_t E_ZERO    = '0;
  localparam out_t E_FETCH   = {4'd0,  8'b0101_0000, 2'b01, 2'b00, 3'b010, 1'b1, 1'b0};
  localparam out_t E_FETCH0  = {4'd0,  8'b0100_0000, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam out_t E_DEC     = {4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam out_t E_DEC_ILL = {4'd1,  8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0, 1'b1};
  localparam out_t E_MADR    = {4'd2,  8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam out_t E_MRD     = {4'd3,  8'b1100_0000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam out_t E_MWB     = {4'd4,  8'b0000_0110, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam out_t E_MWR0    = {4'd5,  8'b1000_0000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam out_t E_MWR1    = {4'd5,  8'b1010_0000, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam out_t E_ALUWB   = {4'd7,  8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam out_t E_BR0     = {4'd8,  8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0, 1'b0};
  localparam out_t E_BR1     = {4'd8,  8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b1, 1'b0};
  localparam out_t E_ADDX    = {4'd9,  8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam out_t E_ADDWB   = {4'd10, 8'b0000_0010, 2'b00, 2'b00, 3'b010, 1'b0, 1'b0};
  localparam out_t E_JMP     = {4'd11, 8'b0000_0000, 2'b00, 2'b10, 3'b010, 1'b1, 1'b0};

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, illegal;
  logic [3:0] state;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .memread(memread), .memwrite(memwrite),
    .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
    .pcen(pcen), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  out_t act;
  assign act = {state, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
                alusrca, alusrcb, pcsrc, alucontrol, pcen, illegal};

  int   n_tests = 0;
  int   n_fail  = 0;
  int   rw_cnt, mw_cnt;
  cyc_t vec[$];
  cyc_t q[$];

  function automatic cyc_t mkc(input logic [5:0] o_, input logic [5:0] f_,
                               input logic z_, input logic r_, input out_t e_);
    cyc_t c;
    c.op = o_; c.funct = f_; c.zero = z_; c.rdy = r_; c.exp = e_;
    return c;
  endfunction

  function automatic out_t e_ex(input logic [2:0] a);
    return {4'd6, 8'b0000_0001, 2'b00, 2'b00, a, 1'b0, 1'b0};
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic check(input string name, input out_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h (state %0d), required %h (state %0d)",
               name, act, act.st, exp, exp.st);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then sample.
  task automatic apply(input cyc_t c, input string name);
    @(negedge clk);
    op = c.op; funct = c.funct; zero = c.zero; mem_ready = c.rdy;
    #1;
    check(name, c.exp);
    rw_cnt += int'(act.regwrite);
    mw_cnt += int'(act.memwrite);
  endtask

  // ---------------- reference model (instruction level) ----------------
  function automatic int kind_of(input logic [5:0] o_, input logic [5:0] f_);
    case (o_)
      OP_LW:   return K_LW;
      OP_SW:   return K_SW;
      OP_R:    return (f_ inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
                      ? K_R : K_ILL;
      OP_BEQ:  return K_BEQ;
      OP_ADDI: return K_ADDI;
      OP_J:    return K_J;
      default: return K_ILL;
    endcase
  endfunction

  // ALU operation requested by an R-type funct.
  function automatic logic [2:0] alu_of(input logic [5:0] f_);
    case (f_)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic out_t idle(input logic [3:0] st);
    out_t o;
    o = '0; o.st = st; o.aluc = 3'b010;
    return o;
  endfunction

  // Expands one instruction into its expected cycle stream, with random
  // wait states on memory steps and random don't-care inputs elsewhere.
  task automatic gen_instr(input logic [5:0] io, input logic [5:0] ifn);
    out_t o;
    int   k, w;
    logic z;
    k = kind_of(io, ifn);
    w = $urandom_range(0, 2);
    for (int i = 0; i <= w; i++) begin
      o = idle(4'd0); o.memread = 1'b1; o.alusrcb = 2'b01;
      o.irwrite = (i == w); o.pcen = (i == w);
      q.push_back(mkc(io, ifn, rbit(), (i == w), o));
    end
    o = idle(4'd1); o.alusrcb = 2'b11; o.illegal = (k == K_ILL);
    q.push_back(mkc(io, ifn, rbit(), rbit(), o));
    case (k)
      K_LW, K_SW: begin
        o = idle(4'd2); o.alusrca = 1'b1; o.alusrcb = 2'b10;
        q.push_back(mkc(io, ifn, rbit(), rbit(), o));
        w = $urandom_range(0, 2);
        for (int i = 0; i <= w; i++) begin
          if (k == K_LW) begin
            o = idle(4'd3); o.iord = 1'b1; o.memread = 1'b1;
          end else begin
            o = idle(4'd5); o.iord = 1'b1; o.memwrite = (i == w);
          end
          q.push_back(mkc(io, ifn, rbit(), (i == w), o));
        end
        if (k == K_LW) begin
          o = idle(4'd4); o.memtoreg = 1'b1; o.regwrite = 1'b1;
          q.push_back(mkc(io, ifn, rbit(), rbit(), o));
        end
      end
      K_R: begin
        o = idle(4'd6); o.alusrca = 1'b1; o.aluc = alu_of(ifn);
        q.push_back(mkc(io, ifn, rbit(), rbit(), o));
        o = idle(4'd7); o.regdst = 1'b1; o.regwrite = 1'b1;
        q.push_back(mkc(io, ifn, rbit(), rbit(), o));
      end
      K_BEQ: begin
        z = rbit();
        o = idle(4'd8); o.alusrca = 1'b1; o.pcsrc = 2'b01; o.aluc = 3'b110; o.pcen = z;
        q.push_back(mkc(io, ifn, z, rbit(), o));
      end
      K_ADDI: begin
        o = idle(4'd9); o.alusrca = 1'b1; o.alusrcb = 2'b10;
        q.push_back(mkc(io, ifn, rbit(), rbit(), o));
        o = idle(4'd10); o.regwrite = 1'b1;
        q.push_back(mkc(io, ifn, rbit(), rbit(), o));
      end
      K_J: begin
        o = idle(4'd11); o.pcsrc = 2'b10; o.pcen = 1'b1;
        q.push_back(mkc(io, ifn, rbit(), rbit(), o));
      end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] legal_f [5];
    logic [2:0] legal_a [5];
    logic [5:0] ro, rf;
    int         k;
    legal_f = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    legal_a = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    // Directed vector table.
    vec.push_back(mkc(OP_LW, 6'd0, 1'b0, 1'b0, E_DEC));
    vec.push_back(mkc(OP_LW, 6'd0, 1'b0, 1'b1, E_MADR));
    vec.push_back(mkc(OP_LW, 6'd0, 1'b0, 1'b1, E_MRD));
    vec.push_back(mkc(OP_LW, 6'd0, 1'b0, 1'b1, E_MWB));
    vec.push_back(mkc(OP_LW, 6'd0, 1'b0, 1'b1, E_FETCH));
    vec.push_back(mkc(OP_LW, 6'd0, 1'b0, 1'b1, E_DEC));
    vec.push_back(mkc(OP_LW, 6'd0, 1'b0, 1'b0, E_MADR));
    vec.push_back(mkc(OP_LW, 6'd0, 1'b0, 1'b0, E_MRD));
    vec.push_back(mkc(OP_LW, 6'd0, 1'b0, 1'b0, E_MRD));
    vec.push_back(mkc(OP_LW, 6'd0, 1'b0, 1'b1, E_MRD));
    vec.push_back(mkc(OP_LW, 6'd0, 1'b0, 1'b0, E_MWB));
    vec.push_back(mkc(OP_SW, 6'd0, 1'b0, 1'b1, E_FETCH));
    vec.push_back(mkc(OP_SW, 6'd0, 1'b0, 1'b1, E_DEC));
    vec.push_back(mkc(OP_SW, 6'd0, 1'b0, 1'b1, E_MADR));
    vec.push_back(mkc(OP_SW, 6'd0, 1'b0, 1'b0, E_MWR0));
    vec.push_back(mkc(OP_SW, 6'd0, 1'b0, 1'b0, E_MWR0));
    vec.push_back(mkc(OP_SW, 6'd0, 1'b0, 1'b1, E_MWR1));
    for (int i = 0; i < 5; i++) begin
      vec.push_back(mkc(OP_R, legal_f[i], 1'b0, 1'b1, E_FETCH));
      vec.push_back(mkc(OP_R, legal_f[i], 1'b1, 1'b0, E_DEC));
      vec.push_back(mkc(OP_R, legal_f[i], 1'b0, 1'b1, e_ex(legal_a[i])));
      vec.push_back(mkc(OP_R, legal_f[i], 1'b1, 1'b0, E_ALUWB));
    end
    vec.push_back(mkc(OP_BEQ, 6'd0, 1'b0, 1'b1, E_FETCH));
    vec.push_back(mkc(OP_BEQ, 6'd0, 1'b0, 1'b1, E_DEC));
    vec.push_back(mkc(OP_BEQ, 6'd0, 1'b1, 1'b1, E_BR1));
    vec.push_back(mkc(OP_BEQ, 6'd0, 1'b1, 1'b1, E_FETCH));
    vec.push_back(mkc(OP_BEQ, 6'd0, 1'b1, 1'b1, E_DEC));
    vec.push_back(mkc(OP_BEQ, 6'd0, 1'b0, 1'b1, E_BR0));
    vec.push_back(mkc(OP_ADDI, 6'd0, 1'b0, 1'b1, E_FETCH));
    vec.push_back(mkc(OP_ADDI, 6'd0, 1'b0, 1'b1, E_DEC));
    vec.push_back(mkc(OP_ADDI, 6'd0, 1'b0, 1'b0, E_ADDX));
    vec.push_back(mkc(OP_ADDI, 6'd0, 1'b0, 1'b1, E_ADDWB));
    vec.push_back(mkc(OP_J, 6'd0, 1'b0, 1'b0, E_FETCH0));
    vec.push_back(mkc(OP_J, 6'd0, 1'b0, 1'b1, E_FETCH));
    vec.push_back(mkc(OP_J, 6'd0, 1'b0, 1'b1, E_DEC));
    vec.push_back(mkc(OP_J, 6'd0, 1'b0, 1'b1, E_JMP));
    vec.push_back(mkc(6'b111111, 6'd0, 1'b0, 1'b1, E_FETCH));
    vec.push_back(mkc(6'b111111, 6'd0, 1'b0, 1'b1, E_DEC_ILL));
    vec.push_back(mkc(OP_R, 6'b000000, 1'b0, 1'b1, E_FETCH));
    vec.push_back(mkc(OP_R, 6'b000000, 1'b0, 1'b1, E_DEC_ILL));

    // Reset held for three cycles with every output at zero.
    reset = 1'b1; op = OP_LW; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    rw_cnt = 0; mw_cnt = 0;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("reset_cycle%0d", i), E_ZERO);
    end
    reset = 1'b1;
    #1 check("first_fetch", E_FETCH);

    for (int i = 0; i < vec.size(); i++) begin
      apply(vec[i], $sformatf("vec%0d", i));
    end

    // Reset asserted mid-EXECUTE: immediate return to FETCH, no write.
    apply(mkc(OP_R, 6'b100000, 1'b0, 1'b1, E_FETCH), "rst_seq_fetch");
    apply(mkc(OP_R, 6'b100000, 1'b0, 1'b1, E_DEC), "rst_seq_dec");
    apply(mkc(OP_R, 6'b100000, 1'b0, 1'b1, e_ex(3'b010)), "rst_seq_exec");
    reset = 1'b0;
    #1 check("rst_mid_exec", E_ZERO);
    @(negedge clk);
    #1 check("rst_held", E_ZERO);
    mem_ready = 1'b0;
    reset = 1'b1;
    #1 check("rst_release", E_FETCH0);

    // Randomized instructions against the model.
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0:       ro = OP_LW;
        1:       ro = OP_SW;
        2, 3:    ro = OP_R;
        4:       ro = OP_BEQ;
        5:       ro = OP_ADDI;
        6:       ro = OP_J;
        default: ro = 6'($urandom);
      endcase
      rf = ($urandom_range(0, 4) == 0) ? 6'($urandom) : legal_f[$urandom_range(0, 4)];
      k = kind_of(ro, rf);
      q.delete();
      gen_instr(ro, rf);
      rw_cnt = 0; mw_cnt = 0;
      foreach (q[i]) apply(q[i], $sformatf("rnd%0d_c%0d_op%b", n, i, ro));
      check_int($sformatf("rnd%0d_regwrite_count", n), rw_cnt,
                (k == K_LW || k == K_R || k == K_ADDI) ? 1 : 0);
      check_int($sformatf("rnd%0d_memwrite_count", n), mw_cnt, (k == K_SW) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Main control FSM for the multicycle MIPS datapath: a single shared memory, an instruction register, and one ALU reused for PC increment, branch target and execution.
- Sequences each instruction through fetch/decode/execute/memory/writeback states and drives every datapath select and enable.
- Includes the ALU function decoder.
- Supports memory wait states via a mem_ready handshake.

Parameters:
- USE_MEMREADY, 1: when 1, the memory states wait for mem_ready; when 0, mem_ready is ignored and treated as constant 1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- op  in  6  instr[31:26] from the instruction register
- funct  in  6  instr[5:0] from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memread  out  1  memory read request
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load enable
- regdst  out  1  write register select: 0 = rt, 1 = rd
- memtoreg  out  1  register write data: 0 = ALUOut, 1 = data register
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = signimm, 11 = signimm<<2
- pcsrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  ALU function: 010 add, 110 sub, 000 and, 001 or, 111 slt
- pcen  out  1  PC register load enable
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- state  out  4  current state, for debug

Behaviour:
- Reset:
  - Asynchronous, active-low; forces state = FETCH (0).
  - While reset is low, all other outputs are 0.
  - Reset mid-instruction aborts with no register or memory write.
- Outputs are Moore decodes of state. The only exceptions are pcen and the mem_ready gating below.
  - pcen = pcwrite | (branch & zero).
- Unlisted outputs are 0 in every state. In particular, alucontrol = 010 unless stated otherwise.
- State encodings and per-state behaviour:
  - FETCH (0): memread=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00. irwrite and pcwrite=1 only in the cycle mem_ready=1, then go to DECODE; otherwise hold.
  - DECODE (1): alusrca=0, alusrcb=11 (precompute branch target into ALUOut). Dispatch on op:
    - 100011 (lw) and 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXECUTE, provided funct ∈ {100000, 100010, 100100, 100101, 101010}
    - 000100 (beq) -> BRANCH
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JUMP
    - Any other op, or an unsupported funct: illegal=1 for this cycle, next state FETCH, no side effects.
  - MEMADR (2): alusrca=1, alusrcb=10. lw -> MEMRD; sw -> MEMWR.
  - MEMRD (3): memread=1, iord=1. Hold until mem_ready, then -> MEMWB.
  - MEMWB (4): regdst=0, memtoreg=1, regwrite=1 -> FETCH.
  - MEMWR (5): iord=1. memwrite=1 only in the cycle mem_ready=1 (single strobe), then -> FETCH; hold otherwise.
  - EXECUTE (6): alusrca=1, alusrcb=00. alucontrol from funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111. Next -> ALUWB.
  - ALUWB (7): regdst=1, memtoreg=0, regwrite=1 -> FETCH.
  - BRANCH (8): alusrca=1, alusrcb=00, alucontrol=110, pcsrc=01, branch=1 -> FETCH.
  - ADDIEX (9): alusrca=1, alusrcb=10, alucontrol=010 -> ADDIWB.
  - ADDIWB (10): regdst=0, memtoreg=0, regwrite=1 -> FETCH.
  - JUMP (11): pcsrc=10, pcwrite=1 -> FETCH.
  - Encodings 12-15 are unreachable; if entered, go to FETCH with all outputs 0.
- Latency with zero wait states, counting FETCH through the last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each cycle with mem_ready low in FETCH, MEMRD or MEMWR adds exactly one cycle.
- When USE_MEMREADY=1, no memory state advances without mem_ready. mem_ready is ignored in all other states.
- regwrite, memwrite and pcen are each asserted at most once per instruction. The exception is FETCH plus a taken beq/j, which gives two pcen pulses.

Test Plan:
- Reset held low 3 cycles, then released with mem_ready=1 -> state=0 and all outputs 0 during reset. First cycle after release: memread=1, alusrcb=01, irwrite=1, pcen=1.
- lw (op 100011), mem_ready always 1 -> states 0,1,2,3,4 in five cycles. regwrite=1 with memtoreg=1 only in state 4; back to 0.
- sw with mem_ready low for 2 cycles in MEMWR -> state 5 held 3 cycles. memwrite is a single pulse, coincident with mem_ready=1.
- R-type sub (funct 100010) -> alucontrol=110 in EXECUTE; ALUWB has regdst=1, regwrite=1. Repeat for and/or/slt, checking 000/001/111.
- beq with zero=1 -> pcen=1, pcsrc=01 in state 8. With zero=0 -> pcen=0, and the next state is 0.
- op 111111, then R-type with funct 000000 -> illegal pulses 1 cycle in DECODE and the next state is FETCH. No regwrite, memwrite or pcen (beyond the fetch pulse). Assert reset mid-EXECUTE -> immediate state 0 with no regwrite.
